retire_trace_fifo: RTL and testbench

//  Sits directly downstream of the core retire ports (retire0..2 pc/vld) in the Verilator top.

---
 rtl/retire_trace_fifo_if.sv | 20 ++
 rtl/retire_trace_fifo.sv | 138 +++++++++++++
 tb/tb_retire_trace_fifo.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/retire_trace_fifo_if.sv
// Drain-side bus of the retire trace FIFO: head record plus valid/ready handshake.
interface retire_trace_fifo_if #(
  parameter int unsigned PC_W = 64
);
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [63:0]     out_cycle;
  logic [1:0]      out_lane;

  modport master (
    output out_valid, out_pc, out_cycle, out_lane,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_pc, out_cycle, out_lane,
    output out_ready
  );
endinterface

// File: rtl/retire_trace_fifo.sv
// Packs up to three retired PCs per cycle into a cycle-stamped FIFO and tracks
// the sticky end-of-test and hang flags for the simulation harness.
module retire_trace_fifo #(
  parameter int unsigned     PC_W       = 64,
  parameter int unsigned     DEPTH      = 16,
  parameter logic [31:0]     IDLE_LIMIT = 32'h8000,
  parameter logic [PC_W-1:0] END_PC     = '0
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   retire0_vld,
  input  logic [PC_W-1:0]        retire0_pc,
  input  logic                   retire1_vld,
  input  logic [PC_W-1:0]        retire1_pc,
  input  logic                   retire2_vld,
  input  logic [PC_W-1:0]        retire2_pc,
  input  logic                   trace_en,
  retire_trace_fifo_if.master    drain,
  output logic [$clog2(DEPTH):0] level,
  output logic [31:0]            drop_cnt,
  output logic                   end_of_test,
  output logic                   hang,
  output logic [PC_W-1:0]        last_pc
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned NL = 3;

  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic [63:0]     cyc_mem  [DEPTH];
  logic [1:0]      lane_mem [DEPTH];

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [63:0]     cycle;
  logic [31:0]     idle;
  logic            started;

  logic [NL-1:0]   vld;
  logic [PC_W-1:0] pc [NL];

  logic            enq;
  logic            pop;
  logic            any_vld;
  logic            hit_end;
  logic [LW-1:0]   free;
  logic [LW-1:0]   n_wr;
  logic [1:0]      n_drop;
  logic [NL-1:0]   wr_en;
  logic [AW-1:0]   wr_idx [NL];
  logic [PC_W-1:0] last_pc_nxt;
  logic [31:0]     idle_nxt;
  logic            started_nxt;
  logic [32:0]     drop_sum;
  logic [31:0]     drop_nxt;

  assign vld   = {retire2_vld, retire1_vld, retire0_vld};
  assign pc[0] = retire0_pc;
  assign pc[1] = retire1_pc;
  assign pc[2] = retire2_pc;

  assign drain.out_valid = (level != '0);
  assign drain.out_pc    = pc_mem[rd_ptr];
  assign drain.out_cycle = cyc_mem[rd_ptr];
  assign drain.out_lane  = lane_mem[rd_ptr];

  // Lane packing against the space left at the start of the cycle; pops do not free slots early.
  always_comb begin
    enq         = trace_en && !end_of_test;
    pop         = (level != '0) && drain.out_ready;
    any_vld     = (|vld) && !end_of_test;
    free        = LW'(DEPTH) - level;
    n_wr        = '0;
    n_drop      = '0;
    wr_en       = '0;
    hit_end     = 1'b0;
    last_pc_nxt = last_pc;
    for (int i = 0; i < NL; i++) begin
      wr_idx[i] = '0;
      if (vld[i]) begin
        if (pc[i] == END_PC) hit_end = 1'b1;
        if (!end_of_test) last_pc_nxt = pc[i];
        if (enq) begin
          if (n_wr < free) begin
            wr_en[i]  = 1'b1;
            wr_idx[i] = wr_ptr + AW'(n_wr);
            n_wr      = n_wr + LW'(1);
          end else begin
            n_drop = n_drop + 2'd1;
          end
        end
      end
    end
    drop_sum    = {1'b0, drop_cnt} + 33'(n_drop);
    drop_nxt    = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    started_nxt = started || any_vld;
    if (any_vld)                   idle_nxt = '0;
    else if (idle == 32'hFFFF_FFFF) idle_nxt = idle;
    else                           idle_nxt = idle + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      drop_cnt    <= '0;
      end_of_test <= 1'b0;
      hang        <= 1'b0;
      last_pc     <= '0;
      cycle       <= '0;
      idle        <= '0;
      started     <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + AW'(n_wr);
      rd_ptr      <= rd_ptr + AW'(pop);
      level       <= level + n_wr - LW'(pop);
      drop_cnt    <= drop_nxt;
      end_of_test <= end_of_test || (hit_end && !end_of_test);
      hang        <= hang || (started_nxt && (idle_nxt >= IDLE_LIMIT) && !end_of_test);
      last_pc     <= last_pc_nxt;
      cycle       <= cycle + 64'd1;
      idle        <= idle_nxt;
      started     <= started_nxt;
    end
  end

  // Record storage carries no reset; occupancy alone says which slots are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (wr_en[i]) begin
        pc_mem[wr_idx[i]]   <= pc[i];
        cyc_mem[wr_idx[i]]  <= cycle;
        lane_mem[wr_idx[i]] <= 2'(i);
      end
    end
  end
endmodule

// File: tb/tb_retire_trace_fifo.sv
// Directed bench for retire_trace_fifo: packing, back-pressure, drops, flags, reset.
module tb_retire_trace_fifo;
  localparam int unsigned PC_W       = 64;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned LW         = 5;
  localparam int unsigned IDLE_LIMIT = 32'h8000;

  logic            clk = 1'b0;
  logic            rst_b;
  logic [2:0]      vld;
  logic [PC_W-1:0] pc0, pc1, pc2;
  logic            trace_en;
  logic [LW-1:0]   level;
  logic [31:0]     drop_cnt;
  logic            end_of_test;
  logic            hang;
  logic [PC_W-1:0] last_pc;
  logic [63:0]     tb_cyc = '0;
  logic [63:0]     stamp;

  int n_checks = 0;
  int n_fail   = 0;

  retire_trace_fifo_if #(.PC_W(PC_W)) drain ();

  retire_trace_fifo #(
    .PC_W(PC_W), .DEPTH(DEPTH), .IDLE_LIMIT(32'h8000), .END_PC(64'h0)
  ) dut (
    .clk(clk), .rst_b(rst_b),
    .retire0_vld(vld[0]), .retire0_pc(pc0),
    .retire1_vld(vld[1]), .retire1_pc(pc1),
    .retire2_vld(vld[2]), .retire2_pc(pc2),
    .trace_en(trace_en), .drain(drain),
    .level(level), .drop_cnt(drop_cnt), .end_of_test(end_of_test),
    .hang(hang), .last_pc(last_pc)
  );

  always #5 clk = ~clk;

  // Expected cycle stamp: counts edges since the last reset edge.
  always @(posedge clk) tb_cyc <= rst_b ? tb_cyc + 64'd1 : 64'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [2:0] v, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c);
    vld = v; pc0 = a; pc1 = b; pc2 = c;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    retire(3'b000, 64'h0, 64'h0, 64'h0);
    drain.out_ready = 1'b0;
    step();
    rst_b = 1'b1;
  endtask

  task automatic check_head(input string tag, input logic [63:0] p, input logic [63:0] cy,
                            input logic [1:0] ln);
    check({tag, "_valid"}, 64'(drain.out_valid), 64'd1);
    check({tag, "_pc"},    drain.out_pc,         p);
    check({tag, "_cycle"}, drain.out_cycle,      cy);
    check({tag, "_lane"},  64'(drain.out_lane),  64'(ln));
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_valid"}, 64'(drain.out_valid), 64'd0);
    check({tag, "_level"}, 64'(level),           64'd0);
    check({tag, "_drop"},  64'(drop_cnt),        64'd0);
    check({tag, "_eot"},   64'(end_of_test),     64'd0);
    check({tag, "_hang"},  64'(hang),            64'd0);
    check({tag, "_lastpc"}, last_pc,             64'd0);
  endtask

  initial begin
    trace_en = 1'b1;
    rst_b    = 1'b0;
    retire(3'b000, 64'h0, 64'h0, 64'h0);
    drain.out_ready = 1'b0;
    step();
    do_reset();
    check_idle_state("reset");

    // Three lanes at stamp 5 stream out on consecutive cycles.
    repeat (5) step();
    drain.out_ready = 1'b1;
    retire(3'b111, 64'hA0, 64'hB0, 64'hC0);
    stamp = tb_cyc;
    check("t1_stamp_base", stamp, 64'd5);
    step();
    retire(3'b000, 64'h0, 64'h0, 64'h0);
    check_head("t1_a", 64'hA0, 64'd5, 2'd0);
    step();
    check_head("t1_b", 64'hB0, 64'd5, 2'd1);
    step();
    check_head("t1_c", 64'hC0, 64'd5, 2'd2);
    step();
    check("t1_empty", 64'(drain.out_valid), 64'd0);

    // Lanes 0 and 2 only: lane 1 is skipped in packing.
    retire(3'b101, 64'h1234, 64'hDEAD, 64'h5678);
    stamp = tb_cyc;
    step();
    retire(3'b000, 64'h0, 64'h0, 64'h0);
    check("t1_lastpc_sparse", last_pc, 64'h5678);
    check_head("sparse_0", 64'h1234, stamp, 2'd0);
    step();
    check_head("sparse_2", 64'h5678, stamp, 2'd2);
    step();
    check("sparse_empty", 64'(level), 64'd0);

    // Tracing disabled: nothing enqueued, last_pc still follows.
    trace_en = 1'b0;
    retire(3'b011, 64'h77, 64'h88, 64'h99);
    step();
    retire(3'b000, 64'h0, 64'h0, 64'h0);
    check("noen_level", 64'(level), 64'd0);
    check("noen_lastpc", last_pc, 64'h88);
    check("noen_drop", 64'(drop_cnt), 64'd0);
    trace_en = 1'b1;

    // Six 3-lane cycles into a stalled 16-deep FIFO.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      retire(3'b111, 64'h100 + 64'(c * 16), 64'h101 + 64'(c * 16), 64'h102 + 64'(c * 16));
      step();
    end
    retire(3'b000, 64'h0, 64'h0, 64'h0);
    check("t2_level", 64'(level), 64'd16);
    check("t2_drop", 64'(drop_cnt), 64'd2);
    check_head("t2_first", 64'h100, 64'd0, 2'd0);
    drain.out_ready = 1'b1;
    repeat (15) step();
    check_head("t2_last", 64'h150, 64'd5, 2'd0);
    step();
    check("t2_drained", 64'(drain.out_valid), 64'd0);

    // level 15, pop and two lanes together: one written, one dropped.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      retire(3'b111, 64'h100 + 64'(c * 16), 64'h101 + 64'(c * 16), 64'h102 + 64'(c * 16));
      step();
    end
    check("t3_pre_level", 64'(level), 64'd15);
    retire(3'b011, 64'h200, 64'h201, 64'h0);
    drain.out_ready = 1'b1;
    step();
    retire(3'b000, 64'h0, 64'h0, 64'h0);
    drain.out_ready = 1'b0;
    check("t3_level", 64'(level), 64'd15);
    check("t3_drop", 64'(drop_cnt), 64'd1);
    check_head("t3_head", 64'h101, 64'd0, 2'd1);

    // END_PC on lane 1: that cycle still enqueued, later retires ignored.
    do_reset();
    retire(3'b111, 64'h10, 64'h0, 64'h30);
    stamp = tb_cyc;
    step();
    check("t4_eot", 64'(end_of_test), 64'd1);
    check("t4_level", 64'(level), 64'd3);
    check("t4_lastpc", last_pc, 64'h30);
    retire(3'b101, 64'h50, 64'h60, 64'h70);
    step();
    retire(3'b000, 64'h0, 64'h0, 64'h0);
    check("t4_level_after", 64'(level), 64'd3);
    check("t4_lastpc_after", last_pc, 64'h30);
    check("t4_eot_sticky", 64'(end_of_test), 64'd1);
    drain.out_ready = 1'b1;
    check_head("t4_r0", 64'h10, stamp, 2'd0);
    step();
    check_head("t4_r1", 64'h0, stamp, 2'd1);
    step();
    check_head("t4_r2", 64'h30, stamp, 2'd2);
    step();
    check("t4_empty", 64'(drain.out_valid), 64'd0);

    // Mid-operation reset with ten records held.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      retire(3'b111, 64'h300 + 64'(c * 4), 64'h301 + 64'(c * 4), 64'h302 + 64'(c * 4));
      step();
    end
    retire(3'b001, 64'h3F0, 64'h0, 64'h0);
    step();
    retire(3'b000, 64'h0, 64'h0, 64'h0);
    check("t6_pre_level", 64'(level), 64'd10);
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    check_idle_state("t6_after_rst");
    retire(3'b001, 64'h3A0, 64'h0, 64'h0);
    drain.out_ready = 1'b1;
    step();
    retire(3'b000, 64'h0, 64'h0, 64'h0);
    check_head("t6_restamp", 64'h3A0, 64'd0, 2'd0);

    // No retire since reset: hang never asserts.
    do_reset();
    repeat (IDLE_LIMIT + 8) step();
    check("t5_no_start", 64'(hang), 64'd0);

    // One retire, then idle: hang rises on the edge idle reaches the limit.
    retire(3'b001, 64'h400, 64'h0, 64'h0);
    step();
    retire(3'b000, 64'h0, 64'h0, 64'h0);
    repeat (IDLE_LIMIT - 1) step();
    check("t5_before", 64'(hang), 64'd0);
    step();
    check("t5_at_limit", 64'(hang), 64'd1);
    retire(3'b001, 64'h404, 64'h0, 64'h0);
    step();
    retire(3'b000, 64'h0, 64'h0, 64'h0);
    check("t5_sticky", 64'(hang), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
